// File: rtl/sudoku_pkg.sv
// Shared types, sizes and helpers for the Sudoku solver pipeline.
package sudoku_pkg;

    localparam int GRID_N = 9;
    localparam int BOX_N  = 3;
    localparam int CELLS  = 81;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        ERROR = 2'd2
    } loader_state_e;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        BAD_VALUE = 2'd1,
        DUPLICATE = 2'd2
    } loader_err_e;

    function automatic logic [3:0] box_of(input logic [3:0] row,
                                          input logic [3:0] col);
        return 4'((32'(row) / BOX_N) * BOX_N + 32'(col) / BOX_N);
    endfunction

endpackage

// File: rtl/sudoku_conflict_tracker.sv
// Row/column/box occupancy masks; flags a given already present
// in the row, column or 3x3 box of the addressed cell.
module sudoku_conflict_tracker
    import sudoku_pkg::*;
#(
    parameter int CHECK_CONFLICTS = 1
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [3:0] row,
    input  logic [3:0] col,
    input  logic [3:0] value,
    input  logic       set,
    input  logic       clear,
    output logic       conflict
);

    logic [8:0] row_mask_q [GRID_N];
    logic [8:0] col_mask_q [GRID_N];
    logic [8:0] box_mask_q [GRID_N];
    logic [8:0] row_mask_d [GRID_N];
    logic [8:0] col_mask_d [GRID_N];
    logic [8:0] box_mask_d [GRID_N];
    logic [8:0] bit_v;
    logic [3:0] box;
    logic       hit;

    always_comb begin
        box = box_of(row, col);
        bit_v = 9'd0;
        if (value >= 4'd1 && value <= 4'd9) begin
            bit_v = 9'(9'd1 << (value - 4'd1));
        end
        row_mask_d = row_mask_q;
        col_mask_d = col_mask_q;
        box_mask_d = box_mask_q;
        if (clear) begin
            for (int i = 0; i < GRID_N; i++) begin
                row_mask_d[i] = '0;
                col_mask_d[i] = '0;
                box_mask_d[i] = '0;
            end
        end else if (set) begin
            row_mask_d[row] = row_mask_q[row] | bit_v;
            col_mask_d[col] = col_mask_q[col] | bit_v;
            box_mask_d[box] = box_mask_q[box] | bit_v;
        end
    end

    assign hit = |((row_mask_q[row] | col_mask_q[col] | box_mask_q[box]) & bit_v);
    assign conflict = (CHECK_CONFLICTS != 0) ? hit : 1'b0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < GRID_N; i++) begin
                row_mask_q[i] <= '0;
                col_mask_q[i] <= '0;
                box_mask_q[i] <= '0;
            end
        end else begin
            row_mask_q <= row_mask_d;
            col_mask_q <= col_mask_d;
            box_mask_q <= box_mask_d;
        end
    end

endmodule

// File: rtl/sudoku_grid_loader.sv
// Streams 81 row-major cells into a 9x9 grid, rejecting illegal
// values and duplicate givens, then holds the grid for the solver.
module sudoku_grid_loader
    import sudoku_pkg::*;
#(
    parameter int CHECK_CONFLICTS = 1
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       cell_valid,
    input  logic [3:0] cell_value,
    output logic       cell_ready,
    input  logic       flush,
    output logic [3:0] grid [GRID_N][GRID_N],
    output logic       grid_valid,
    input  logic       grid_ready,
    output logic [6:0] given_count,
    output logic       err,
    output logic [1:0] err_code,
    output logic [6:0] err_index
);

    loader_state_e state_q, state_d;
    loader_err_e   code_q, code_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;
    logic [6:0]    given_q, given_d;
    logic [6:0]    index_q, index_d;
    logic [3:0]    grid_q [GRID_N][GRID_N];
    logic [3:0]    grid_d [GRID_N][GRID_N];
    logic [6:0]    cell_index;
    logic          set, clear, conflict;

    sudoku_conflict_tracker #(
        .CHECK_CONFLICTS(CHECK_CONFLICTS)
    ) u_tracker (
        .clk     (clk),
        .rst_b   (rst_b),
        .row     (row_q),
        .col     (col_q),
        .value   (cell_value),
        .set     (set),
        .clear   (clear),
        .conflict(conflict)
    );

    assign cell_index = 7'({3'd0, row_q} * 7'd9 + {3'd0, col_q});

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        row_d   = row_q;
        col_d   = col_q;
        given_d = given_q;
        index_d = index_q;
        grid_d  = grid_q;
        set     = 1'b0;
        clear   = 1'b0;
        if (flush) begin
            state_d = FILL;
            code_d  = NONE;
            row_d   = '0;
            col_d   = '0;
            given_d = '0;
            index_d = '0;
            clear   = 1'b1;
            for (int r = 0; r < GRID_N; r++) begin
                for (int c = 0; c < GRID_N; c++) begin
                    grid_d[r][c] = '0;
                end
            end
        end else begin
            unique case (state_q)
                FILL: begin
                    if (cell_valid) begin
                        if (cell_value > 4'd9) begin
                            state_d = ERROR;
                            code_d  = BAD_VALUE;
                            index_d = cell_index;
                        end else if (conflict) begin
                            state_d = ERROR;
                            code_d  = DUPLICATE;
                            index_d = cell_index;
                        end else begin
                            grid_d[row_q][col_q] = cell_value;
                            if (cell_value != 4'd0) begin
                                set     = 1'b1;
                                given_d = given_q + 7'd1;
                            end
                            if (col_q == 4'd8) begin
                                if (row_q == 4'd8) begin
                                    state_d = HOLD;
                                end else begin
                                    col_d = '0;
                                    row_d = row_q + 4'd1;
                                end
                            end else begin
                                col_d = col_q + 4'd1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (grid_ready) begin
                        state_d = FILL;
                        row_d   = '0;
                        col_d   = '0;
                        given_d = '0;
                        clear   = 1'b1;
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= FILL;
            code_q  <= NONE;
            row_q   <= '0;
            col_q   <= '0;
            given_q <= '0;
            index_q <= '0;
            for (int r = 0; r < GRID_N; r++) begin
                for (int c = 0; c < GRID_N; c++) begin
                    grid_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            row_q   <= row_d;
            col_q   <= col_d;
            given_q <= given_d;
            index_q <= index_d;
            grid_q  <= grid_d;
        end
    end

    assign cell_ready  = (state_q == FILL);
    assign grid_valid  = (state_q == HOLD);
    assign err         = (state_q == ERROR);
    assign err_code    = code_q;
    assign err_index   = index_q;
    assign given_count = given_q;
    assign grid        = grid_q;

endmodule

// File: tb/tb_sudoku_grid_loader.sv
// Randomized bench for sudoku_grid_loader against a rule-level model
// of Sudoku legality (per-row/col/box digit sets).
module tb_sudoku_grid_loader;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       cell_valid;
    logic [3:0] cell_value;
    logic       flush;
    logic       grid_ready;

    logic       cell_ready, grid_valid, err;
    logic [3:0] grid [9][9];
    logic [6:0] given_count, err_index;
    logic [1:0] err_code;

    logic       nc_ready, nc_valid, nc_err;
    logic [3:0] nc_grid [9][9];
    logic [6:0] nc_given, nc_index;
    logic [1:0] nc_code;

    int checks = 0;
    int failures = 0;

    logic [3:0] stim [81];
    logic [3:0] fixed_puz [81];
    int perm [10];

    sudoku_grid_loader #(.CHECK_CONFLICTS(1)) dut (
        .clk(clk), .rst_b(rst_b),
        .cell_valid(cell_valid), .cell_value(cell_value),
        .cell_ready(cell_ready), .flush(flush),
        .grid(grid), .grid_valid(grid_valid), .grid_ready(grid_ready),
        .given_count(given_count), .err(err),
        .err_code(err_code), .err_index(err_index)
    );

    sudoku_grid_loader #(.CHECK_CONFLICTS(0)) dut_nc (
        .clk(clk), .rst_b(rst_b),
        .cell_valid(cell_valid), .cell_value(cell_value),
        .cell_ready(nc_ready), .flush(flush),
        .grid(nc_grid), .grid_valid(nc_valid), .grid_ready(grid_ready),
        .given_count(nc_given), .err(nc_err),
        .err_code(nc_code), .err_index(nc_index)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cell_valid = 1'b0;
        grid_ready = 1'b0;
        step();
        flush = 1'b0;
    endtask

    // Solution grid from the shifted-row pattern, digits relabelled by perm.
    function automatic logic [3:0] sol(input int i);
        int r, c;
        r = i / 9;
        c = i % 9;
        return 4'(perm[((r * 3 + r / 3 + c) % 9) + 1]);
    endfunction

    task automatic shuffle_perm();
        int j, t;
        for (int k = 0; k < 10; k++) perm[k] = k;
        for (int k = 9; k >= 2; k--) begin
            j = $urandom_range(k, 1);
            t = perm[k];
            perm[k] = perm[j];
            perm[j] = t;
        end
    endtask

    task automatic model(input bit chk, output int code, output int idx,
                         output int gc);
        int rm[9], cm[9], bm[9];
        int r, c, b, x;
        code = 0;
        idx = 0;
        gc = 0;
        for (int k = 0; k < 9; k++) begin
            rm[k] = 0; cm[k] = 0; bm[k] = 0;
        end
        for (int i = 0; i < 81; i++) begin
            r = i / 9;
            c = i % 9;
            b = (r / 3) * 3 + c / 3;
            x = int'(stim[i]);
            if (x > 9) begin
                code = 1; idx = i; return;
            end
            if (x != 0) begin
                if (chk && (((rm[r] | cm[c] | bm[b]) & (1 << x)) != 0)) begin
                    code = 2; idx = i; return;
                end
                rm[r] |= (1 << x);
                cm[c] |= (1 << x);
                bm[b] |= (1 << x);
                gc++;
            end
        end
    endtask

    function automatic int grid_errs(input bit use_nc, input int lim);
        int n;
        logic [3:0] exp, got;
        n = 0;
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                exp = (r * 9 + c < lim) ? stim[r * 9 + c] : 4'd0;
                got = use_nc ? nc_grid[r][c] : grid[r][c];
                if (got !== exp) n++;
            end
        end
        return n;
    endfunction

    task automatic send(input bit watch_nc, input int stall_pct,
                        input int limit, output int sent);
        sent = 0;
        for (int i = 0; i < limit; i++) begin
            for (int k = 0; k < 20 && $urandom_range(99, 0) < stall_pct; k++) begin
                cell_valid = 1'b0;
                step();
            end
            if (!(watch_nc ? nc_ready : cell_ready)) break;
            cell_valid = 1'b1;
            cell_value = stim[i];
            step();
            sent++;
        end
        cell_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        cell_valid = 1'b0;
        cell_value = 4'd0;
        flush = 1'b0;
        grid_ready = 1'b0;
        for (int i = 0; i < 81; i++) stim[i] = 4'd0;
        #3;
        checks++;
        if ({grid_valid, err, err_code} !== 4'b0000 || given_count !== 7'd0 ||
            err_index !== 7'd0) begin
            failures++;
            $display("FAIL reset_outputs got gv=%b err=%b code=%0d gc=%0d idx=%0d want 0",
                     grid_valid, err, err_code, given_count, err_index);
        end
        checks++;
        if (grid_errs(0, 0) != 0) begin
            failures++;
            $display("FAIL reset_grid got %0d nonzero cells want 0", grid_errs(0, 0));
        end
        @(negedge clk);
        rst_b = 1'b1;
        step();
        checks++;
        if (cell_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", cell_ready);
        end
    endtask

    task automatic test_full_puzzle();
        for (int k = 0; k < 10; k++) perm[k] = k;
        for (int i = 0; i < 81; i++) begin
            fixed_puz[i] = ((i * 7) % 81 < 30) ? sol(i) : 4'd0;
            stim[i] = fixed_puz[i];
        end
        for (int i = 0; i < 81; i++) begin
            cell_valid = 1'b1;
            cell_value = stim[i];
            step();
            if (i == 79) begin
                checks++;
                if (grid_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL full_early_valid got=%b want=0", grid_valid);
                end
            end
        end
        cell_valid = 1'b0;
        checks++;
        if (grid_valid !== 1'b1 || cell_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_valid got gv=%b rdy=%b want gv=1 rdy=0",
                     grid_valid, cell_ready);
        end
        checks++;
        if (given_count !== 7'd30) begin
            failures++;
            $display("FAIL full_given got=%0d want=30", given_count);
        end
        for (int k = 0; k < 10; k++) begin
            cell_valid = 1'b1;
            cell_value = 4'd3;
            step();
            checks++;
            if (grid_valid !== 1'b1 || grid_errs(0, 81) != 0 || given_count !== 7'd30) begin
                failures++;
                $display("FAIL full_hold_%0d got gv=%b bad_cells=%0d gc=%0d want 1/0/30",
                         k, grid_valid, grid_errs(0, 81), given_count);
            end
        end
        cell_valid = 1'b0;
        grid_ready = 1'b1;
        step();
        grid_ready = 1'b0;
        checks++;
        if (grid_valid !== 1'b0 || cell_ready !== 1'b1 || given_count !== 7'd0) begin
            failures++;
            $display("FAIL full_release got gv=%b rdy=%b gc=%0d want 0/1/0",
                     grid_valid, cell_ready, given_count);
        end
        checks++;
        if (grid_errs(0, 81) != 0) begin
            failures++;
            $display("FAIL full_release_grid got %0d changed cells want 0",
                     grid_errs(0, 81));
        end
    endtask

    task automatic test_bad_value();
        int sent;
        do_flush();
        for (int i = 0; i < 81; i++) stim[i] = fixed_puz[i];
        stim[40] = 4'd12;
        send(0, 0, 81, sent);
        checks++;
        if (sent !== 41 || err !== 1'b1 || err_code !== 2'd1 || err_index !== 7'd40 ||
            cell_ready !== 1'b0) begin
            failures++;
            $display("FAIL bad_value got sent=%0d err=%b code=%0d idx=%0d rdy=%b want 41/1/1/40/0",
                     sent, err, err_code, err_index, cell_ready);
        end
        checks++;
        if (grid[4][4] !== 4'd0 || grid_errs(0, 40) != 0) begin
            failures++;
            $display("FAIL bad_value_grid got g44=%0d bad=%0d want 0/0",
                     grid[4][4], grid_errs(0, 40));
        end
        cell_valid = 1'b1;
        cell_value = 4'd15;
        grid_ready = 1'b1;
        step();
        step();
        cell_valid = 1'b0;
        grid_ready = 1'b0;
        checks++;
        if (err !== 1'b1 || err_code !== 2'd1 || err_index !== 7'd40) begin
            failures++;
            $display("FAIL bad_value_frozen got err=%b code=%0d idx=%0d want 1/1/40",
                     err, err_code, err_index);
        end
    endtask

    task automatic test_duplicate();
        int sent;
        do_flush();
        for (int i = 0; i < 81; i++) stim[i] = 4'd0;
        stim[0] = 4'd5;
        stim[20] = 4'd5;
        send(0, 0, 81, sent);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || err_index !== 7'd20 || given_count !== 7'd1) begin
            failures++;
            $display("FAIL dup_box got err=%b code=%0d idx=%0d gc=%0d want 1/2/20/1",
                     err, err_code, err_index, given_count);
        end
        do_flush();
        send(1, 0, 81, sent);
        checks++;
        if (sent !== 81 || nc_valid !== 1'b1 || nc_err !== 1'b0 || nc_given !== 7'd2 ||
            grid_errs(1, 81) != 0) begin
            failures++;
            $display("FAIL dup_nocheck got sent=%0d gv=%b err=%b gc=%0d bad=%0d want 81/1/0/2/0",
                     sent, nc_valid, nc_err, nc_given, grid_errs(1, 81));
        end
    endtask

    task automatic test_random_stalls();
        int sent;
        do_flush();
        for (int i = 0; i < 81; i++) stim[i] = fixed_puz[i];
        send(0, 50, 81, sent);
        checks++;
        if (grid_valid !== 1'b1 || given_count !== 7'd30 || grid_errs(0, 81) != 0) begin
            failures++;
            $display("FAIL stalls got gv=%b gc=%0d bad=%0d want 1/30/0",
                     grid_valid, given_count, grid_errs(0, 81));
        end
    endtask

    task automatic test_flush();
        int sent;
        do_flush();
        for (int i = 0; i < 81; i++) stim[i] = fixed_puz[i];
        send(0, 0, 60, sent);
        flush = 1'b1;
        cell_valid = 1'b1;
        cell_value = 4'd9;
        step();
        flush = 1'b0;
        cell_valid = 1'b0;
        checks++;
        if (grid_errs(0, 0) != 0 || given_count !== 7'd0 || cell_ready !== 1'b1 ||
            err !== 1'b0) begin
            failures++;
            $display("FAIL flush_mid got bad=%0d gc=%0d rdy=%b err=%b want 0/0/1/0",
                     grid_errs(0, 0), given_count, cell_ready, err);
        end
        cell_valid = 1'b1;
        cell_value = 4'd7;
        step();
        cell_valid = 1'b0;
        checks++;
        if (grid[0][0] !== 4'd7 || grid[0][1] !== 4'd0 || given_count !== 7'd1) begin
            failures++;
            $display("FAIL flush_next got g00=%0d g01=%0d gc=%0d want 7/0/1",
                     grid[0][0], grid[0][1], given_count);
        end
        do_flush();
        send(0, 0, 81, sent);
        flush = 1'b1;
        grid_ready = 1'b1;
        step();
        flush = 1'b0;
        grid_ready = 1'b0;
        checks++;
        if (grid_errs(0, 0) != 0 || grid_valid !== 1'b0 || cell_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_vs_ready got bad=%0d gv=%b rdy=%b want 0/0/1",
                     grid_errs(0, 0), grid_valid, cell_ready);
        end
    endtask

    task automatic test_reset_midload();
        int sent;
        do_flush();
        for (int i = 0; i < 81; i++) stim[i] = fixed_puz[i];
        send(0, 0, 30, sent);
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (grid_errs(0, 0) != 0 || given_count !== 7'd0 || grid_valid !== 1'b0 ||
            err !== 1'b0 || err_code !== 2'd0 || err_index !== 7'd0 || cell_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got bad=%0d gc=%0d gv=%b err=%b want 0/0/0/0",
                     grid_errs(0, 0), given_count, grid_valid, err);
        end
        cell_valid = 1'b1;
        cell_value = 4'd4;
        step();
        checks++;
        if (grid[0][0] !== 4'd0 || given_count !== 7'd0) begin
            failures++;
            $display("FAIL reset_hold got g00=%0d gc=%0d want 0/0", grid[0][0], given_count);
        end
        cell_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        step();
    endtask

    task automatic test_random_loads();
        int sent, code, idx, gc, lim, dens, stall;
        for (int it = 0; it < 24; it++) begin
            shuffle_perm();
            dens = $urandom_range(70, 15);
            for (int i = 0; i < 81; i++) begin
                stim[i] = ($urandom_range(99, 0) < dens) ? sol(i) : 4'd0;
            end
            if ($urandom_range(1, 0) == 1) begin
                stim[$urandom_range(80, 0)] = 4'($urandom_range(15, 1));
            end
            stall = $urandom_range(60, 0);
            for (int pass = 0; pass < 2; pass++) begin
                model(pass == 0, code, idx, gc);
                lim = (code != 0) ? idx : 81;
                do_flush();
                send(pass == 1, stall, 81, sent);
                step();
                checks++;
                if (pass == 0) begin
                    if (grid_valid !== (code == 0) || err !== (code != 0) ||
                        int'(err_code) != code || int'(err_index) != idx ||
                        int'(given_count) != gc || grid_errs(0, lim) != 0) begin
                        failures++;
                        $display("FAIL rand_%0d got gv=%b code=%0d idx=%0d gc=%0d bad=%0d want code=%0d idx=%0d gc=%0d",
                                 it, grid_valid, err_code, err_index, given_count,
                                 grid_errs(0, lim), code, idx, gc);
                    end
                end else begin
                    if (nc_valid !== (code == 0) || nc_err !== (code != 0) ||
                        int'(nc_code) != code || int'(nc_index) != idx ||
                        int'(nc_given) != gc || grid_errs(1, lim) != 0) begin
                        failures++;
                        $display("FAIL rand_nc_%0d got gv=%b code=%0d idx=%0d gc=%0d bad=%0d want code=%0d idx=%0d gc=%0d",
                                 it, nc_valid, nc_code, nc_index, nc_given,
                                 grid_errs(1, lim), code, idx, gc);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_puzzle();
        test_bad_value();
        test_duplicate();
        test_random_stalls();
        test_flush();
        test_reset_midload();
        test_random_loads();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sudoku_grid_loader.md
# sudoku_grid_loader

Front-end stage of the Sudoku solver. Accepts a puzzle as a row-major stream of 81 cell values over a valid/ready handshake and assembles it into a 9×9 grid register. Rejects out-of-range values and, when enabled, duplicate givens within a row, column or 3×3 subgrid. Holds the completed grid stable, with `grid_valid`, until the solver core takes it through `grid_ready`.

## Interface
Parameters:
- `CHECK_CONFLICTS`, default 1: 1 enables duplicate-given detection; 0 performs the range check only.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_b` input 1: asynchronous, active-low reset.
- `cell_valid` input 1: `cell_value` is presented this cycle.
- `cell_value` input 4: 0 = empty cell; 1–9 = given; 10–15 = illegal.
- `cell_ready` output 1: loader accepts a cell this cycle. Decoded from state only; never depends on `cell_valid`.
- `flush` input 1: synchronous abort and clear. Returns to FILL from any state.
- `grid` output `[3:0] [9][9]`: assembled puzzle, indexed `[row][col]`; feeds the solver's `in_grid`.
- `grid_valid` output 1: `grid` is complete and legal.
- `grid_ready` input 1: solver consumes the grid.
- `given_count` output 7: number of non-zero cells accepted so far, 0–81.
- `err` output 1: load aborted on an error.
- `err_code` output 2: 0 = NONE, 1 = BAD_VALUE, 2 = DUPLICATE.
- `err_index` output 7: row-major index, 0–80, of the offending cell.

## Operation
State machine with three states; FILL is the reset state.

**FILL**
- `cell_ready` = 1. A transfer is `cell_valid & cell_ready`.
- On a transfer at position (`row`, `col`), box index `(row/3)*3 + col/3`, the checks run in this priority order:
  1. `cell_value` > 9: go to ERROR with `err_code` = BAD_VALUE and `err_index` = `row*9 + col`. The grid is not written.
  2. Value is non-zero, `CHECK_CONFLICTS` = 1, and bit `v-1` is already set in `row_mask[row]`, `col_mask[col]` or `box_mask[box]`: go to ERROR with `err_code` = DUPLICATE. The grid is not written.
  3. Otherwise: write `grid[row][col]`. If non-zero, set bit `v-1` in all three masks and increment `given_count`. Then advance `col`; when `col` = 8, wrap `col` to 0 and increment `row`.
- A legal transfer at (8,8) goes to HOLD. `row` and `col` stop there; they do not wrap to 9.

**HOLD**
- `grid_valid` = 1, `cell_ready` = 0. `grid` and `given_count` are frozen.
- `grid_valid & grid_ready`: go to FILL. Clear `row`, `col`, all masks and `given_count`. `grid` keeps its old contents until it is overwritten cell by cell.

**ERROR**
- `err` = 1, `cell_ready` = 0. `err_code`, `err_index` and `grid` are frozen.
- Leaves only on `flush`.

**Flush**
- Has priority over every other event in the same cycle, including a transfer or a `grid_ready` handshake.
- Next state is FILL. `grid` is zeroed; `row`, `col`, masks, `given_count`, `err`, `err_code` and `err_index` are cleared.
- Any `cell_valid` in the flush cycle is dropped.

**Reset values**
- State FILL, so `cell_ready` = 1 once `rst_b` is high.
- `grid` all 0, `grid_valid` 0, `given_count` 0, `err` 0, `err_code` NONE, `err_index` 0, masks 0.
- Reset asserted mid-load discards the partial grid immediately and asynchronously.

## Timing
- Throughput: one cell per cycle. A full load takes a minimum of 81 cycles.
- `grid_valid` rises in the cycle after the 81st cell is accepted.
- `err` rises in the cycle after the offending transfer. `cell_ready` is low in that same cycle.
- HOLD handshake: `grid_valid` falls and `cell_ready` rises in the cycle after `grid_valid & grid_ready`.
- `grid_ready` while `grid_valid` = 0 is ignored.
- Stalls (`cell_valid` = 0) do not advance the position.

## Structure
- Shared `sudoku_pkg` holds:
  - `loader_state_e` {FILL, HOLD, ERROR};
  - `loader_err_e` {NONE, BAD_VALUE, DUPLICATE};
  - constants `GRID_N` = 9, `BOX_N` = 3, `CELLS` = 81;
  - the `box_of(row, col)` function.

  The solver core uses the same constants.
- One sub-module, `sudoku_conflict_tracker`, holds the 27 nine-bit masks. It provides:
  - a combinational `conflict` output for (`row`, `col`, `value`);
  - a `set` strobe;
  - a `clear` strobe.

  With `CHECK_CONFLICTS` = 0 its `conflict` output is tied to 0.

## Test plan
- **Full puzzle:** stream a known 30-given puzzle with no stalls. Expect `grid_valid` high at cycle 82, `given_count` = 30, and `grid` matching the input cell for cell. Holding `grid_ready` = 0 for 10 cycles keeps `grid` stable; `grid_ready` = 1 then produces `grid_valid` = 0 and `cell_ready` = 1 on the next cycle.
- **Bad value:** send `cell_value` = 12 at index 40. Expect `err` = 1, `err_code` = 1, `err_index` = 40, `cell_ready` = 0, and `grid[4][4]` unchanged.
- **Duplicate in subgrid:** send 5 at (0,0) and 5 at (2,2). Expect `err_code` = 2, `err_index` = 20. Repeat with `CHECK_CONFLICTS` = 0: the load completes.
- **Random stalls:** drive `cell_valid` low about 50% of cycles. The resulting grid must be identical to the no-stall run.
- **Flush and reset mid-load:** assert `flush` together with `cell_valid` at index 60. Expect the grid zeroed, `given_count` = 0, and the next cell landing at (0,0). Separately, assert `rst_b` low mid-load; all outputs must read their reset values while it is low.
